// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// input_conditioner
//   Synchronises and debounces the 10 slide switches and 4 pushbuttons feeding
//   the seven-segment digit decoder. Each of the 14 bits passes a 2-flop
//   synchroniser and then an independent debounce counter. The clean level
//   only changes after the synchronised input has differed from it for
//   DEBOUNCE_CYCLES consecutive clocks. Buttons also produce registered
//   one-cycle press/release pulses. The switch bank is checked for one-hot
//   and encoded.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sw_raw       [9:0] slide switch pins (asynchronous)
//   btn_raw      [3:0] pushbutton pins (asynchronous, polarity per BTN_ACTIVE_LOW)
//   sw_clean     [9:0] debounced switch levels
//   btn_clean    [3:0] debounced button levels, 1 = pressed
//   btn_press    [3:0] one-cycle pulse when btn_clean[i] rises
//   btn_release  [3:0] one-cycle pulse when btn_clean[i] falls
//   sw_onehot    1 iff exactly one bit of sw_clean is set
//   sw_index     [3:0] index of the set switch when sw_onehot, else 4'hF
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 0,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw_raw,
    input  logic [3:0] btn_raw,
    output logic [9:0] sw_clean,
    output logic [3:0] btn_clean,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic       sw_onehot,
    output logic [3:0] sw_index
);

    localparam int               NCH      = 14;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       BTN_INV  = (BTN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [NCH-1:0]   raw_in;
    logic [NCH-1:0]   sync_p0;
    logic [NCH-1:0]   sync_p1;
    logic [NCH-1:0]   clean_p2;
    logic [CNT_W-1:0] cnt_p2 [NCH];
    logic [NCH-1:0]   flip;

    // Buttons are normalised to active-high before synchronisation so that
    // everything downstream is polarity-agnostic. Buttons occupy bits 13:10.
    assign raw_in = {btn_raw ^ BTN_INV, sw_raw};

    // A channel commits its new level on the edge where the counter has
    // already seen DEBOUNCE_CYCLES-1 mismatching clocks and the input still
    // disagrees; that edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
        flip = '0;
        for (int i = 0; i < NCH; i++) begin
            flip[i] = (sync_p1[i] != clean_p2[i]) && (cnt_p2[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0     <= '0;
            sync_p1     <= '0;
            clean_p2    <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            // stage p0/p1: two-flop synchroniser
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;

            // stage p2: debounce; any agreement clears progress, counter
            // stops at CNT_LAST because the commit resets it
            for (int i = 0; i < NCH; i++) begin
                if (sync_p1[i] == clean_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (flip[i]) begin
                    clean_p2[i] <= sync_p1[i];
                    cnt_p2[i]   <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end
            end

            // Pulses are registered alongside the commit so they coincide
            // with the first cycle btn_clean shows the new level.
            btn_press   <= flip[13:10] &  sync_p1[13:10];
            btn_release <= flip[13:10] & ~sync_p1[13:10];
        end
    end

    assign sw_clean  = clean_p2[9:0];
    assign btn_clean = clean_p2[13:10];

    // One-hot check and encode of the switch bank
    logic [3:0] ones;
    logic [3:0] idx;

    always_comb begin
        ones = 4'd0;
        idx  = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (sw_clean[k]) begin
                ones = ones + 4'd1;
                idx  = 4'(k);
            end
        end
        sw_onehot = (ones == 4'd1);
        sw_index  = (ones == 4'd1) ? idx : 4'hF;
    end

endmodule
